// File: rtl/elevator_pkg.sv
// Shared elevator types: controller states and keypad command codes.
package elevator_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MOVE_UP,
    ST_MOVE_DOWN,
    ST_DOOR_OPEN,
    ST_ESTOP
  } state_e;

  localparam logic [3:0] KEY_OPEN  = 4'hA;
  localparam logic [3:0] KEY_CLOSE = 4'hB;
  localparam logic [3:0] KEY_ESTOP = 4'hF;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter that saturates at zero; shared by travel and door timing.
module countdown_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_enable,
  output logic             o_zero
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_count <= '0;
    else if (i_load)
      r_count <= i_value;
    else if (i_enable && (r_count != '0))
      r_count <= r_count - WIDTH'(1);
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/floor_scheduler.sv
// Single-car elevator scheduler: keypad calls, travel/door sequencing and emergency stop.
module floor_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned FLOORS      = 10,
  parameter int unsigned FLOOR_TICKS = 64,
  parameter int unsigned DOOR_TICKS  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        key_code,
  input  logic              key_valid,
  output logic [3:0]        current_floor,
  output logic [FLOORS-1:0] pending,
  output logic              motor_up,
  output logic              motor_down,
  output logic              door_open,
  output logic              dir_up,
  output logic              estop
);

  localparam int unsigned TMAX = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
  localparam int unsigned TW   = (TMAX < 2) ? 1 : $clog2(TMAX);
  localparam logic [TW-1:0] FLOOR_LOAD = TW'(FLOOR_TICKS - 1);
  localparam logic [TW-1:0] DOOR_LOAD  = TW'(DOOR_TICKS - 1);

  state_e            r_state, w_state_nxt;
  logic [3:0]        r_floor, w_floor_nxt;
  logic [FLOORS-1:0] r_pending, w_pend_nxt, w_call_mask;
  logic              r_dir_up, w_dir_nxt;
  logic              r_key_prev;
  logic              w_evt, w_is_call, w_here, w_above, w_below;
  logic              w_load, w_en, w_zero;
  logic [TW-1:0]     w_load_val;

  countdown_timer #(.WIDTH(TW)) u_timer (
    .i_clk    (clk),
    .i_rst_n  (rst),
    .i_load   (w_load),
    .i_value  (w_load_val),
    .i_enable (w_en),
    .o_zero   (w_zero)
  );

  assign w_evt       = key_valid & ~r_key_prev;
  assign w_is_call   = w_evt && ({28'd0, key_code} < FLOORS);
  assign w_here      = (key_code == r_floor);
  assign w_call_mask = w_is_call ? (FLOORS'(1) << key_code) : '0;

  always_comb begin
    w_above = 1'b0;
    w_below = 1'b0;
    for (int unsigned i = 0; i < FLOORS; i++) begin
      if (r_pending[i] && (i > 32'(r_floor))) w_above = 1'b1;
      if (r_pending[i] && (i < 32'(r_floor))) w_below = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_floor    <= '0;
      r_pending  <= '0;
      r_dir_up   <= 1'b1;
      r_key_prev <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_floor    <= w_floor_nxt;
      r_pending  <= w_pend_nxt;
      r_dir_up   <= w_dir_nxt;
      r_key_prev <= key_valid;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_floor_nxt = r_floor;
    w_pend_nxt  = r_pending;
    w_dir_nxt   = r_dir_up;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_en        = 1'b0;
    if (r_state == ST_ESTOP) begin
      if (w_evt && (key_code == KEY_ESTOP)) w_state_nxt = ST_IDLE;
    end else if (w_evt && (key_code == KEY_ESTOP)) begin
      w_state_nxt = ST_ESTOP;
      w_pend_nxt  = '0;
      w_load      = 1'b1;
    end else begin
      if (w_is_call && !w_here) w_pend_nxt = r_pending | w_call_mask;
      case (r_state)
        ST_IDLE: begin
          if (w_is_call && w_here) begin
            w_state_nxt = ST_DOOR_OPEN;
            w_load      = 1'b1;
            w_load_val  = DOOR_LOAD;
          end else if (r_pending != '0) begin
            w_load     = 1'b1;
            w_load_val = FLOOR_LOAD;
            if (r_dir_up && w_above) begin
              w_state_nxt = ST_MOVE_UP;
            end else if (w_below) begin
              w_state_nxt = ST_MOVE_DOWN;
              w_dir_nxt   = 1'b0;
            end else begin
              w_state_nxt = ST_MOVE_UP;
              w_dir_nxt   = 1'b1;
            end
          end
        end
        ST_DOOR_OPEN: begin
          if ((w_is_call && w_here) || (w_evt && (key_code == KEY_OPEN))) begin
            w_load     = 1'b1;
            w_load_val = DOOR_LOAD;
          end else if ((w_evt && (key_code == KEY_CLOSE)) || w_zero) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_en = 1'b1;
          end
        end
        ST_MOVE_UP, ST_MOVE_DOWN: begin
          if (w_zero) begin
            if (r_state == ST_MOVE_UP)
              w_floor_nxt = (r_floor < 4'(FLOORS - 1)) ? r_floor + 4'd1 : r_floor;
            else
              w_floor_nxt = (r_floor != 4'd0) ? r_floor - 4'd1 : r_floor;
            w_load = 1'b1;
            // A call landing on the arrival floor this cycle is absorbed by the stop.
            if ((w_pend_nxt & (FLOORS'(1) << w_floor_nxt)) != '0) begin
              w_pend_nxt  = w_pend_nxt & ~(FLOORS'(1) << w_floor_nxt);
              w_state_nxt = ST_DOOR_OPEN;
              w_load_val  = DOOR_LOAD;
            end else begin
              w_load_val  = FLOOR_LOAD;
            end
          end else begin
            w_en = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign current_floor = r_floor;
  assign pending       = r_pending;
  assign dir_up        = r_dir_up;
  assign motor_up      = (r_state == ST_MOVE_UP);
  assign motor_down    = (r_state == ST_MOVE_DOWN);
  assign door_open     = (r_state == ST_DOOR_OPEN);
  assign estop         = (r_state == ST_ESTOP);

endmodule

// File: tb/tb_floor_scheduler.sv
// Scoreboard bench for floor_scheduler: expected output snapshots queued at stimulus time.
module tb_floor_scheduler;
  import elevator_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key_code;
  logic       key_valid;
  logic [3:0] current_floor;
  logic [9:0] pending;
  logic       motor_up, motor_down, door_open, dir_up, estop;

  typedef struct packed {
    logic [3:0] fl;
    logic [9:0] pd;
    logic       mu, md, dr, dir, es;
  } snap_t;

  typedef struct {
    int    at;
    snap_t s;
  } exp_t;

  exp_t  q[$];
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  snap_t cur, last;
  bit    have   = 1'b0;
  exp_t  e;

  floor_scheduler #(.FLOORS(10), .FLOOR_TICKS(4), .DOOR_TICKS(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .key_code      (key_code),
    .key_valid     (key_valid),
    .current_floor (current_floor),
    .pending       (pending),
    .motor_up      (motor_up),
    .motor_down    (motor_down),
    .door_open     (door_open),
    .dir_up        (dir_up),
    .estop         (estop)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void push_exp(int at, int fl, int pd, bit mu, bit md, bit dr, bit dir, bit es);
    exp_t x;
    x.at   = at;
    x.s.fl = 4'(fl);
    x.s.pd = 10'(pd);
    x.s.mu = mu;
    x.s.md = md;
    x.s.dr = dr;
    x.s.dir = dir;
    x.s.es = es;
    q.push_back(x);
  endfunction

  task automatic wait_cyc(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic press(input int t, input logic [3:0] code);
    wait_cyc(t);
    key_code  = code;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  // Monitor: every change of the output vector consumes one expected snapshot.
  initial begin
    forever begin
      @(negedge clk or negedge rst);
      #1;
      cur = {current_floor, pending, motor_up, motor_down, door_open, dir_up, estop};
      checks++;
      if (motor_up && motor_down) begin
        errors++;
        $display("FAIL motor_excl cyc=%0d: up=%b down=%b, required never both", cyc, motor_up, motor_down);
      end
      if (!have || (cur !== last)) begin
        have = 1'b1;
        last = cur;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d: fl=%0d pd=%h mu=%b md=%b door=%b dir=%b es=%b, required no change",
                   cyc, cur.fl, cur.pd, cur.mu, cur.md, cur.dr, cur.dir, cur.es);
        end else begin
          e = q.pop_front();
          if ((cur !== e.s) || ((e.at >= 0) && (e.at != cyc)))
            begin
              errors++;
              $display("FAIL obs: got cyc=%0d fl=%0d pd=%h mu=%b md=%b door=%b dir=%b es=%b, required cyc=%0d fl=%0d pd=%h mu=%b md=%b door=%b dir=%b es=%b",
                       cyc, cur.fl, cur.pd, cur.mu, cur.md, cur.dr, cur.dir, cur.es,
                       e.at, e.s.fl, e.s.pd, e.s.mu, e.s.md, e.s.dr, e.s.dir, e.s.es);
            end
        end
      end
    end
  end

  initial begin
    rst       = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    push_exp(-1, 0, 'h000, 0, 0, 0, 1, 0);
    wait_cyc(3);
    rst = 1'b1;

    // Single call to floor 3 from reset.
    push_exp(6,  0, 'h008, 0, 0, 0, 1, 0);
    push_exp(7,  0, 'h008, 1, 0, 0, 1, 0);
    push_exp(11, 1, 'h008, 1, 0, 0, 1, 0);
    push_exp(15, 2, 'h008, 1, 0, 0, 1, 0);
    push_exp(19, 3, 'h000, 0, 0, 1, 1, 0);
    push_exp(27, 3, 'h000, 0, 0, 0, 1, 0);
    press(5, 4'd3);

    // Up to 7 with 2 called at floor 5, then reversal down to 2.
    push_exp(31, 3, 'h080, 0, 0, 0, 1, 0);
    push_exp(32, 3, 'h080, 1, 0, 0, 1, 0);
    push_exp(36, 4, 'h080, 1, 0, 0, 1, 0);
    push_exp(40, 5, 'h080, 1, 0, 0, 1, 0);
    push_exp(42, 5, 'h084, 1, 0, 0, 1, 0);
    push_exp(44, 6, 'h084, 1, 0, 0, 1, 0);
    push_exp(48, 7, 'h004, 0, 0, 1, 1, 0);
    push_exp(56, 7, 'h004, 0, 0, 0, 1, 0);
    push_exp(57, 7, 'h004, 0, 1, 0, 0, 0);
    push_exp(61, 6, 'h004, 0, 1, 0, 0, 0);
    push_exp(65, 5, 'h004, 0, 1, 0, 0, 0);
    push_exp(69, 4, 'h004, 0, 1, 0, 0, 0);
    push_exp(73, 3, 'h004, 0, 1, 0, 0, 0);
    push_exp(77, 2, 'h000, 0, 0, 1, 0, 0);
    push_exp(85, 2, 'h000, 0, 0, 0, 0, 0);
    press(30, 4'd7);
    press(41, 4'd2);

    // Door: same-floor call, reopen key, close key, and both keys ignored in IDLE.
    push_exp(91,  2, 'h000, 0, 0, 1, 0, 0);
    push_exp(105, 2, 'h000, 0, 0, 0, 0, 0);
    push_exp(111, 2, 'h000, 0, 0, 1, 0, 0);
    push_exp(114, 2, 'h000, 0, 0, 0, 0, 0);
    press(90,  4'd2);
    press(96,  KEY_OPEN);
    press(110, 4'd2);
    press(113, KEY_CLOSE);
    press(117, KEY_OPEN);
    press(119, KEY_CLOSE);

    // Emergency stop between floors 4 and 5; calls ignored; fresh travel afterwards.
    push_exp(126, 2, 'h020, 0, 0, 0, 0, 0);
    push_exp(127, 2, 'h020, 1, 0, 0, 1, 0);
    push_exp(131, 3, 'h020, 1, 0, 0, 1, 0);
    push_exp(135, 4, 'h020, 1, 0, 0, 1, 0);
    push_exp(137, 4, 'h000, 0, 0, 0, 1, 1);
    push_exp(144, 4, 'h000, 0, 0, 0, 1, 0);
    push_exp(148, 4, 'h020, 0, 0, 0, 1, 0);
    push_exp(149, 4, 'h020, 1, 0, 0, 1, 0);
    push_exp(153, 5, 'h000, 0, 0, 1, 1, 0);
    push_exp(161, 5, 'h000, 0, 0, 0, 1, 0);
    press(125, 4'd5);
    press(136, KEY_ESTOP);
    press(139, 4'd6);
    press(141, KEY_OPEN);
    press(143, KEY_ESTOP);
    press(147, 4'd5);

    // Held key 8 for 20 cycles gives one event; then reset during upward travel.
    push_exp(166, 5, 'h100, 0, 0, 0, 1, 0);
    push_exp(167, 5, 'h100, 1, 0, 0, 1, 0);
    push_exp(171, 6, 'h100, 1, 0, 0, 1, 0);
    push_exp(175, 7, 'h100, 1, 0, 0, 1, 0);
    push_exp(179, 8, 'h000, 0, 0, 1, 1, 0);
    push_exp(187, 8, 'h000, 0, 0, 0, 1, 0);
    push_exp(191, 8, 'h200, 0, 0, 0, 1, 0);
    push_exp(192, 8, 'h200, 1, 0, 0, 1, 0);
    push_exp(194, 0, 'h000, 0, 0, 0, 1, 0);
    wait_cyc(165);
    key_code  = 4'd8;
    key_valid = 1'b1;
    wait_cyc(185);
    key_valid = 1'b0;
    press(190, 4'd9);
    wait_cyc(194);
    #2 rst = 1'b0;
    wait_cyc(197);
    rst = 1'b1;

    wait_cyc(200);
    while (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_change: no output change observed, required cyc=%0d fl=%0d pd=%h mu=%b md=%b door=%b dir=%b es=%b",
               e.at, e.s.fl, e.s.pd, e.s.mu, e.s.md, e.s.dr, e.s.dir, e.s.es);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
